// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: set-2 constants, event record,
// decoder state encoding and the US-layout ASCII translation.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bytes following E1 that belong to the Pause key sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ps2_event_t;

    localparam int unsigned EV_BITS = $bits(ps2_event_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_SKIP
    } ps2_state_t;

    // Keyboard status/response bytes that never start a key event
    function automatic logic ps2_is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Alphabet position 1..26 of a letter key, 0 for anything else
    function automatic logic [4:0] ps2_letter_index(input logic [7:0] code);
        case (code)
            8'h1C: return 5'd1;  8'h32: return 5'd2;  8'h21: return 5'd3;
            8'h23: return 5'd4;  8'h24: return 5'd5;  8'h2B: return 5'd6;
            8'h34: return 5'd7;  8'h33: return 5'd8;  8'h43: return 5'd9;
            8'h3B: return 5'd10; 8'h42: return 5'd11; 8'h4B: return 5'd12;
            8'h3A: return 5'd13; 8'h31: return 5'd14; 8'h44: return 5'd15;
            8'h4D: return 5'd16; 8'h15: return 5'd17; 8'h2D: return 5'd18;
            8'h1B: return 5'd19; 8'h2C: return 5'd20; 8'h3C: return 5'd21;
            8'h2A: return 5'd22; 8'h1D: return 5'd23; 8'h22: return 5'd24;
            8'h35: return 5'd25; 8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift,
                                                input logic caps, input logic ctrl);
        logic [4:0] idx;
        logic [7:0] lo;
        logic [7:0] hi;
        idx = ps2_letter_index(code);
        lo  = '0;
        hi  = '0;
        case (code)
            8'h16: begin lo = 8'h31; hi = 8'h21; end
            8'h1E: begin lo = 8'h32; hi = 8'h40; end
            8'h26: begin lo = 8'h33; hi = 8'h23; end
            8'h25: begin lo = 8'h34; hi = 8'h24; end
            8'h2E: begin lo = 8'h35; hi = 8'h25; end
            8'h36: begin lo = 8'h36; hi = 8'h5E; end
            8'h3D: begin lo = 8'h37; hi = 8'h26; end
            8'h3E: begin lo = 8'h38; hi = 8'h2A; end
            8'h46: begin lo = 8'h39; hi = 8'h28; end
            8'h45: begin lo = 8'h30; hi = 8'h29; end
            8'h0E: begin lo = 8'h60; hi = 8'h7E; end
            8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
            8'h55: begin lo = 8'h3D; hi = 8'h2B; end
            8'h54: begin lo = 8'h5B; hi = 8'h7B; end
            8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
            8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
            8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = 8'h2C; hi = 8'h3C; end
            8'h49: begin lo = 8'h2E; hi = 8'h3E; end
            8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
            8'h29: begin lo = 8'h20; hi = 8'h20; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            8'h0D: begin lo = 8'h09; hi = 8'h09; end
            8'h76: begin lo = 8'h1B; hi = 8'h1B; end
            default: ;
        endcase
        if (idx != 5'd0) begin
            if (ctrl)
                return {3'b000, idx};
            else if (shift ^ caps)
                return 8'h40 + {3'b000, idx};
            else
                return 8'h60 + {3'b000, idx};
        end
        return shift ? hi : lo;
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_fifo.sv
// Show-ahead event FIFO (module ps2_event_fifo) used when PS2_EVENT_FIFO_EN is defined.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [EV_BITS-1:0] push_data,
    input  logic               pop,
    output logic [EV_BITS-1:0] pop_data,
    output logic               empty,
    output logic               overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EV_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            overflow <= push & ~do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events with modifier/Caps Lock tracking.
// Define PS2_EVENT_FIFO_EN to buffer events in a FIFO_DEPTH-entry FIFO.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic [7:0] event_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       caps_lock,
    output logic       overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    ps2_state_t state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       emit;
    ps2_event_t dec_ev;
    ps2_event_t out_ev;

    logic lshift_held, rshift_held, lctrl_held, rctrl_held, lalt_held, ralt_held;
    logic caps_held;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    always_comb begin
        state_next   = state;
        skip_next    = skip_cnt;
        emit         = 1'b0;
        dec_ev       = '0;
        dec_ev.code  = rx_data;
        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == SC_E0) begin
                        state_next = ST_E0;
                    end else if (rx_data == SC_F0) begin
                        state_next = ST_F0;
                    end else if (rx_data == SC_E1) begin
                        state_next = ST_SKIP;
                        skip_next  = PAUSE_SKIP;
                    end else if (!ps2_is_ignored(rx_data)) begin
                        emit = 1'b1;
                    end
                end
                ST_E0: begin
                    state_next = ST_IDLE;
                    if (rx_data == SC_F0) begin
                        state_next = ST_E0F0;
                    end else if (rx_data != SC_LSHIFT && rx_data != SC_RSHIFT) begin
                        emit       = 1'b1;
                        dec_ev.ext = 1'b1;
                    end
                end
                ST_F0: begin
                    state_next = ST_IDLE;
                    emit       = 1'b1;
                    dec_ev.brk = 1'b1;
                end
                ST_E0F0: begin
                    state_next = ST_IDLE;
                    if (rx_data != SC_LSHIFT && rx_data != SC_RSHIFT) begin
                        emit       = 1'b1;
                        dec_ev.ext = 1'b1;
                        dec_ev.brk = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_next   = '0;
                        state_next  = ST_IDLE;
                        emit        = 1'b1;
                        dec_ev.code = SC_E1;
                        dec_ev.ext  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        // Uses modifier state as it was before this event touches it
        if (emit && !dec_ev.ext && !dec_ev.brk)
            dec_ev.ascii = ps2_to_ascii(dec_ev.code, mod_shift, caps_lock, mod_ctrl);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            lctrl_held  <= 1'b0;
            rctrl_held  <= 1'b0;
            lalt_held   <= 1'b0;
            ralt_held   <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
        end else if (emit) begin
            case (dec_ev.code)
                SC_LSHIFT: if (!dec_ev.ext) lshift_held <= ~dec_ev.brk;
                SC_RSHIFT: if (!dec_ev.ext) rshift_held <= ~dec_ev.brk;
                SC_CTRL: begin
                    if (dec_ev.ext) rctrl_held <= ~dec_ev.brk;
                    else            lctrl_held <= ~dec_ev.brk;
                end
                SC_ALT: begin
                    if (dec_ev.ext) ralt_held <= ~dec_ev.brk;
                    else            lalt_held <= ~dec_ev.brk;
                end
                SC_CAPS: begin
                    if (!dec_ev.ext) begin
                        if (!dec_ev.brk && !caps_held) caps_lock <= ~caps_lock;
                        caps_held <= ~dec_ev.brk;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mod_shift = lshift_held | rshift_held;
    assign mod_ctrl  = lctrl_held | rctrl_held;
    assign mod_alt   = lalt_held | ralt_held;

`ifdef PS2_EVENT_FIFO_EN
    ps2_event_t         stage_ev;
    logic               stage_push;
    logic [EV_BITS-1:0] fifo_data;
    logic               fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_ev   <= '0;
            stage_push <= 1'b0;
        end else begin
            stage_ev   <= dec_ev;
            stage_push <= emit;
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (stage_push),
        .push_data(stage_ev),
        .pop      (event_valid & event_ready),
        .pop_data (fifo_data),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign event_valid = ~fifo_empty;
    assign out_ev      = fifo_empty ? '0 : ps2_event_t'(fifo_data);
`else
    logic out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ev    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (emit) begin
                if (!out_valid || event_ready) begin
                    out_ev    <= dec_ev;
                    out_valid <= 1'b1;
                end else begin
                    overflow  <= 1'b1;
                end
            end else if (out_valid && event_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign event_valid = out_valid;
`endif

    assign event_code  = out_ev.code;
    assign event_ext   = out_ev.ext;
    assign event_break = out_ev.brk;
    assign event_ascii = out_ev.ascii;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed byte sequences push expected
// events; a monitor pops and compares on every accepted event.
module tb_ps2_scancode_decoder;

`ifdef PS2_EVENT_FIFO_EN
    localparam int unsigned CAP = 4;
`else
    localparam int unsigned CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = '0;
    logic       event_ready = 1'b1;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic [7:0] event_ascii;
    logic       mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;
    logic [17:0] exp_q[$];

    ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .event_valid(event_valid), .event_ready(event_ready), .event_code(event_code),
        .event_ext(event_ext), .event_break(event_break), .event_ascii(event_ascii),
        .mod_shift(mod_shift), .mod_ctrl(mod_ctrl), .mod_alt(mod_alt),
        .caps_lock(caps_lock), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                             input logic [7:0] ascii);
        exp_q.push_back({code, ext, brk, ascii});
    endtask

    task automatic tick(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("drain_pending", exp_q.size(), 0);
        idle(3);
    endtask

    always @(negedge clk) begin
        if (!reset && overflow) ovf_cnt++;
        if (!reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {14'd0, event_code, event_ext, event_break, event_ascii}, 32'hFFFF_FFFF);
            end else begin
                chk("event", {14'd0, event_code, event_ext, event_break, event_ascii},
                    {14'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int ovf_before;
        idle(2);
        chk("rst_valid", event_valid, 0);
        chk("rst_fields", {event_code, event_ext, event_break, event_ascii}, 0);
        chk("rst_mods", {mod_shift, mod_ctrl, mod_alt, caps_lock, overflow}, 0);
        reset = 1'b0;
        idle(2);

        // plain make/break
        expect_ev(8'h1C, 0, 0, 8'h61); tick(8'h1C);
        tick(8'hF0); expect_ev(8'h1C, 0, 1, 8'h00); tick(8'h1C);
        tick(8'hAA); tick(8'hFA);

        // shift
        expect_ev(8'h12, 0, 0, 8'h00); tick(8'h12);
        chk("shift_on", mod_shift, 1);
        expect_ev(8'h1C, 0, 0, 8'h41); tick(8'h1C);
        expect_ev(8'h16, 0, 0, 8'h21); tick(8'h16);
        tick(8'hF0); expect_ev(8'h12, 0, 1, 8'h00); tick(8'h12);
        chk("shift_off", mod_shift, 0);
        expect_ev(8'h16, 0, 0, 8'h31); tick(8'h16);
        expect_ev(8'h5A, 0, 0, 8'h0D); tick(8'h5A);
        expect_ev(8'h29, 0, 0, 8'h20); tick(8'h29);
        drain();

        // extended keys and fake shifts
        tick(8'hE0); expect_ev(8'h75, 1, 0, 8'h00); tick(8'h75);
        tick(8'hE0); tick(8'hF0); expect_ev(8'h75, 1, 1, 8'h00); tick(8'h75);
        tick(8'hE0); tick(8'h12);
        tick(8'hE0); tick(8'hF0); tick(8'h12);
        chk("fake_shift", mod_shift, 0);
        drain();

        // caps lock with typematic repeat
        repeat (3) begin expect_ev(8'h58, 0, 0, 8'h00); tick(8'h58); end
        tick(8'hF0); expect_ev(8'h58, 0, 1, 8'h00); tick(8'h58);
        chk("caps_on", caps_lock, 1);
        expect_ev(8'h1C, 0, 0, 8'h41); tick(8'h1C);
        expect_ev(8'h12, 0, 0, 8'h00); tick(8'h12);
        expect_ev(8'h1C, 0, 0, 8'h61); tick(8'h1C);
        tick(8'hF0); expect_ev(8'h12, 0, 1, 8'h00); tick(8'h12);
        expect_ev(8'h58, 0, 0, 8'h00); tick(8'h58);
        chk("caps_off", caps_lock, 0);
        tick(8'hF0); expect_ev(8'h58, 0, 1, 8'h00); tick(8'h58);
        expect_ev(8'h1C, 0, 0, 8'h61); tick(8'h1C);
        drain();

        // pause sequence, ctrl, alt
        expect_ev(8'hE1, 1, 0, 8'h00);
        tick(8'hE1); tick(8'h14); tick(8'h77); tick(8'hE1);
        tick(8'hF0); tick(8'h14); tick(8'hF0); tick(8'h77);
        chk("pause_no_ctrl", mod_ctrl, 0);
        expect_ev(8'h14, 0, 0, 8'h00); tick(8'h14);
        chk("ctrl_on", mod_ctrl, 1);
        expect_ev(8'h21, 0, 0, 8'h03); tick(8'h21);
        tick(8'hF0); expect_ev(8'h14, 0, 1, 8'h00); tick(8'h14);
        chk("ctrl_off", mod_ctrl, 0);
        tick(8'hE0); expect_ev(8'h14, 1, 0, 8'h00); tick(8'h14);
        chk("rctrl_on", mod_ctrl, 1);
        tick(8'hE0); tick(8'hF0); expect_ev(8'h14, 1, 1, 8'h00); tick(8'h14);
        expect_ev(8'h11, 0, 0, 8'h00); tick(8'h11);
        chk("alt_on", mod_alt, 1);
        tick(8'hF0); expect_ev(8'h11, 0, 1, 8'h00); tick(8'h11);
        chk("alt_off", mod_alt, 0);
        drain();

        // back-pressure and overflow
        chk("no_ovf_yet", ovf_cnt, 0);
        ovf_before  = ovf_cnt;
        event_ready = 1'b0;
        begin
            logic [7:0] keys [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
            logic [7:0] asc  [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
            for (int i = 0; i <= CAP; i++) begin
                if (i < CAP) expect_ev(keys[i], 0, 0, asc[i]);
                tick(keys[i]);
            end
        end
        idle(3);
        chk("held_valid", event_valid, 1);
        chk("held_code_a", event_code, 8'h1C);
        idle(2);
        chk("held_code_b", {event_code, event_ascii}, 16'h1C61);
        chk("ovf_pulses", ovf_cnt - ovf_before, 1);
        event_ready = 1'b1;
        drain();

        // reset mid-sequence discards prefix and queued event
        event_ready = 1'b0;
        tick(8'h1C);
        tick(8'hE0);
        idle(2);
        reset = 1'b1;
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("post_rst_valid", event_valid, 0);
        chk("post_rst_state", {mod_shift, mod_ctrl, caps_lock, overflow}, 0);
        event_ready = 1'b1;
        expect_ev(8'h75, 0, 0, 8'h00); tick(8'h75);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the PS/2 receiver's byte stream (`rx_data` qualified by `rx_done_tick`, scan code set 2) into whole key events. Each event carries make/break, the extended flag, the base code and an ASCII translation. The block also holds live modifier and Caps Lock state. It sits between the PS/2 receiver and the terminal input logic, which pulls events through a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of two, at least 2. Used only when `PS2_EVENT_FIFO_EN` is defined.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte
- `rx_data`  in  8  received scan-code byte
- `event_valid`  out  1  event available
- `event_ready`  in  1  consumer accepts the event when `event_valid & event_ready`
- `event_code`  out  8  base scan code, with prefixes stripped
- `event_ext`  out  1  key was E0-prefixed, or is the Pause key
- `event_break`  out  1  1 = key release, 0 = key press
- `event_ascii`  out  8  translated character; 0 if non-printable or on break
- `mod_shift`, `mod_ctrl`, `mod_alt`, `caps_lock`  out  1 each  live modifier state
- `overflow`  out  1  one-cycle pulse: a decoded event was dropped

## Operation
- Bytes are consumed only on `rx_done_tick`. Between ticks the decoder state holds.
- The decoder FSM has states IDLE, E0, F0, E0F0 and SKIP.
- IDLE:
  - E0 → E0; F0 → F0; E1 → SKIP with skip counter = 7.
  - 00, AA, FA, FC, FE and FF are ignored, and the FSM stays in IDLE.
  - Any other byte emits a make event with ext=0.
- E0:
  - F0 → E0F0.
  - 12 and 59 (fake shifts) are discarded → IDLE.
  - Any other byte emits a make event with ext=1 → IDLE.
- F0: the next byte emits a break event with ext=0 → IDLE.
- E0F0: 12 and 59 are discarded; any other byte emits a break event with ext=1. Either way → IDLE.
- SKIP:
  - Each byte decrements the counter.
  - When the counter reaches 0, emit one make event with code E1, ext=1 → IDLE.
- Modifier tracking:
  - `mod_shift` = left shift (12) held OR right shift (59) held. These are tracked separately.
  - `mod_ctrl` = 14 held, ext=0 or ext=1 (either Ctrl).
  - `mod_alt` = 11 held, ext=0 or ext=1 (either Alt).
- Caps Lock: `caps_lock` toggles on a make of 58 only when 58 is not already held. Typematic repeats therefore do not toggle it. A 58 break clears the held flag.
- ASCII is produced on make events with ext=0 only. It is computed from the modifier state before that event updates it.
  - Letters: lowercase; uppercase when `mod_shift` XOR `caps_lock`.
  - Digits and punctuation: unshifted or shifted US layout according to `mod_shift`.
  - Fixed codes: 29→20, 5A→0D, 66→08, 0D→09, 76→1B.
  - With `mod_ctrl` held, letters give 01–1A (a=01 … z=1A).
  - All other keys give 00.

## Timing
- Reset values: `event_valid`=0, `event_code`=0, `event_ext`=0, `event_break`=0, `event_ascii`=0, all modifiers 0, `caps_lock`=0, `overflow`=0. FSM returns to IDLE and the skip counter to 0.
- Reset mid-sequence discards any pending prefix and all queued events.
- Latency, no FIFO: a tick in cycle N that completes an event gives `event_valid`=1 in cycle N+1.
- Modifier and `caps_lock` outputs update in cycle N+1 in both configurations.
- Handshake:
  - Event fields stay stable while `event_valid & ~event_ready`.
  - `event_valid` drops the cycle after acceptance unless a new event is loaded.

## Configuration
- `PS2_EVENT_FIFO_EN` defined:
  - Events pass through a `FIFO_DEPTH`-entry show-ahead FIFO, with `event_valid` = not empty.
  - First-event latency is N+2.
  - Push while full drops the event and pulses `overflow`.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted.
- `PS2_EVENT_FIFO_EN` undefined:
  - A single output register is used.
  - A new event while `event_valid & ~event_ready` is dropped and `overflow` pulses; the held event is kept.
  - A new event in the same cycle as acceptance replaces the register, and `event_valid` stays 1.

## Structure
- Shared package `ps2_pkg` holds:
  - scan-code constants (E0, F0, E1, 12, 59, 14, 11, 58);
  - the event struct {code, ext, brk, ascii};
  - the FSM state enum;
  - function `ps2_to_ascii(code, shift, caps, ctrl)`.
- One sub-module, `ps2_event_fifo`, instantiated only under `PS2_EVENT_FIFO_EN`.

## Test plan
- Tick 1C → event code 1C, ext 0, break 0, ascii 61. Then F0,1C → break event, ascii 00.
- 12 make, 1C, F0 12 → events 12, 1C (ascii 41), 12-break; `mod_shift` goes 1 then 0.
- E0 75 then E0 F0 75 → code 75 ext 1 make, then break. E0 12 alone produces no event.
- 58 make ×3, then F0 58 → `caps_lock`=1. Then 58 again → `caps_lock`=0. Next, 1C → ascii 61.
- E1 14 77 E1 F0 14 F0 77 → exactly one event, code E1 ext 1. 14 → `mod_ctrl` then 21 → ascii 03.
- `event_ready`=0 with events 1C,32,21,23,24 → FIFO holds 4 and the 5th pulses `overflow` (1 pulse without FIFO, holding 1C). Reset asserted after E0 → next byte 75 gives ext 0.
